// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared opcodes, pc_sel encodings and fetch FSM states for the
//               3-stage RISC-V core.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] REGREG = 7'b0110011;
  localparam logic [6:0] REGIMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] NOP    = 7'b0000000;

  // Bubble injected whenever no fetched instruction is available
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Next-PC select from the control logic
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_TARGET = 2'b01;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : DEPTH-entry synchronous FIFO of {pc, inst}. Flush beats push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end: PC generation, in-order imem
//               requests, response buffering and redirect/discard handling.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BUF_DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [31:0] target_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
);

  fetch_state_t state, state_nx;

  logic [31:0] fetch_pc;
  logic [1:0]  outstanding, out_nx;
  logic [1:0]  discard_cnt;
  logic [31:0] pcq [4];
  logic [1:0]  pcq_wr, pcq_rd;

  logic        redirect, fire, rsp, drop, push, pop;
  logic [63:0] buf_rdata;
  logic        buf_full, buf_empty;
  logic [$clog2(BUF_DEPTH):0] buf_count;
  int          occ;

  assign redirect    = (pc_sel_i == PC_SEL_TARGET);
  assign fire        = imem_req_o && imem_gnt_i;
  assign rsp         = imem_rvalid_i && (outstanding != 2'd0);
  assign drop        = rsp && (discard_cnt != 2'd0);
  assign push        = rsp && !drop;
  assign pop         = !redirect && !stall_i && !buf_empty;
  assign imem_addr_o = fetch_pc;

  logic unused_bits;
  assign unused_bits = &{1'b0, target_i[1:0], buf_full};

  // Request gating, outstanding update and next-state selection
  always_comb begin
    occ        = int'(outstanding) + int'(buf_count);
    imem_req_o = (state == RUN) && (occ < MAX_OUTSTANDING) && (occ < BUF_DEPTH);
    out_nx     = outstanding;
    if ((imem_req_o && imem_gnt_i) && !rsp)      out_nx = outstanding + 2'd1;
    else if (!(imem_req_o && imem_gnt_i) && rsp) out_nx = outstanding - 2'd1;
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     state_nx = RUN;
      DRAIN:   if (discard_cnt == 2'd0 || (drop && discard_cnt == 2'd1)) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
    // Everything still in flight after this cycle is stale on a redirect
    if (redirect) state_nx = (out_nx != 2'd0) ? DRAIN : RUN;
  end

  // FSM state, fetch PC and response accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      discard_cnt <= 2'd0;
      pcq_wr      <= 2'd0;
      pcq_rd      <= 2'd0;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;
      if (redirect)  fetch_pc <= {target_i[31:2], 2'b00};
      else if (fire) fetch_pc <= fetch_pc + 32'd4;
      if (redirect)  discard_cnt <= out_nx;
      else if (drop) discard_cnt <= discard_cnt - 2'd1;
      if (fire) pcq_wr <= (pcq_wr == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : pcq_wr + 2'd1;
      if (rsp)  pcq_rd <= (pcq_rd == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : pcq_rd + 2'd1;
    end
  end

  // Per-request PC record, matched to responses in order
  always_ff @(posedge clk) begin
    if (fire) pcq[pcq_wr] <= fetch_pc;
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({pcq[pcq_rd], imem_rdata_i}),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Output register: redirect bubbles, stall holds, otherwise pop or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o       <= NOP_INST;
      pc_o         <= 32'h0;
      inst_valid_o <= 1'b0;
    end else if (redirect) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (!buf_empty) begin
        pc_o         <= buf_rdata[63:32];
        inst_o       <= buf_rdata[31:0];
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a random in-order memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, stall_i, inst_valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, target_i, inst_o, pc_o;
  logic [1:0]  pc_sel_i;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(2), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .pc_sel_i(pc_sel_i), .target_i(target_i),
    .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o)
  );

  typedef struct { logic [31:0] addr; int ready; } mreq_t;
  mreq_t       mem_q[$];      // granted requests awaiting a memory response
  logic [31:0] exp_q[$];      // PCs expected to appear on pc_o, in order
  logic [31:0] exp_fetch;     // address the next granted request must carry
  int total = 0, bad = 0, cyc = 0, n_insts = 0;
  int gnt_pct = 100, stall_pct = 0, redir_pct = 0, lat_min = 0, lat_max = 0;
  logic        prev_stall = 1'b0, prev_redir = 1'b0, last_valid = 1'b0;
  logic [31:0] last_inst = '0, last_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compares presented instructions and request addresses
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_fetch  = RESET_PC;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      last_valid = 1'b0;
      last_inst  = '0;
      last_pc    = '0;
    end else begin
      if (prev_redir) begin
        check("redir_valid", {31'b0, inst_valid_o}, 32'd0);
        check("redir_inst", inst_o, 32'd0);
      end else if (prev_stall) begin
        check("hold_inst", inst_o, last_inst);
        check("hold_pc", pc_o, last_pc);
        check("hold_valid", {31'b0, inst_valid_o}, {31'b0, last_valid});
      end else if (inst_valid_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_inst: got pc %h inst %h want none", pc_o, inst_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("inst_pc", pc_o, e);
          check("inst_word", inst_o, e ^ KEY);
          n_insts++;
        end
      end else begin
        check("bubble_inst", inst_o, 32'd0);
      end
      if (imem_req_o && imem_gnt_i) begin
        check("req_addr", imem_addr_o, exp_fetch);
        mem_q.push_back('{imem_addr_o, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
        if (pc_sel_i != 2'b01) exp_q.push_back(exp_fetch);
        exp_fetch += 32'd4;
      end
      if (pc_sel_i == 2'b01) begin
        exp_q.delete();
        exp_fetch = {target_i[31:2], 2'b00};
      end
      prev_stall = stall_i;
      prev_redir = (pc_sel_i == 2'b01);
      last_inst  = inst_o;
      last_pc    = pc_o;
      last_valid = inst_valid_o;
    end
  end

  function automatic logic [31:0] rand_target();
    if ($urandom_range(1, 0) == 1) return $urandom_range(32'h400, 0);
    return 32'hFFFF_FFE0 | $urandom_range(31, 0);
  endfunction

  // One cycle of stimulus: memory response plus randomized controls
  task automatic step();
    int s;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      mreq_t m;
      m = mem_q.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = m.addr ^ KEY;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    imem_gnt_i = (int'($urandom_range(99, 0)) < gnt_pct);
    stall_i    = (int'($urandom_range(99, 0)) < stall_pct);
    target_i   = rand_target();
    if (int'($urandom_range(99, 0)) < redir_pct) begin
      pc_sel_i = 2'b01;
    end else begin
      s = int'($urandom_range(2, 0));
      pc_sel_i = (s == 0) ? 2'b00 : ((s == 1) ? 2'b10 : 2'b11);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (inst_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic expect_first(input string name, input logic [31:0] pc);
    bit ok;
    wait_valid(40, ok);
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: got no valid inst want pc %h", name, pc);
    end else begin
      check(name, pc_o, pc);
    end
  endtask

  // Wait for two requests in flight and a response-free cycle, then redirect
  task automatic redirect_with_pending(input logic [31:0] tgt);
    bit found = 1'b0;
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (mem_q.size() == 2 && !imem_rvalid_i) found = 1'b1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL pending_setup: got %0d in flight want 2", mem_q.size());
    end
    pc_sel_i = 2'b01;
    target_i = tgt;
    lat_min = 0; lat_max = 0;
  endtask

  initial begin
    bit ok;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    stall_i = 1'b0; pc_sel_i = 2'b00; target_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);

    // Release mid-cycle: BOOT shows no request, then sequential fetch from 0
    @(negedge clk); #2 rst = 1'b0;
    #1 check("boot_req", {31'b0, imem_req_o}, 32'd0);
    step();
    check("run_req", {31'b0, imem_req_o}, 32'd1);
    check("first_addr", imem_addr_o, RESET_PC);
    expect_first("first_pc", RESET_PC);
    check("first_word", inst_o, KEY);
    repeat (10) step();

    // Three stall cycles; requests must stop once two are in flight/buffered
    stall_pct = 100;
    repeat (3) step();
    stall_pct = 0;
    step();
    check("stall_req_off", {31'b0, imem_req_o}, 32'd0);
    repeat (10) step();

    // Redirect with two stale requests: requests pause while draining
    redirect_with_pending(32'h0000_0103);
    step();
    check("drain_req_off", {31'b0, imem_req_o}, 32'd0);
    expect_first("redir_pc", 32'h0000_0100);
    repeat (5) step();

    // Redirect coinciding with a response and a grant
    begin
      bit found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        step();
        if (imem_rvalid_i && imem_req_o && imem_gnt_i) found = 1'b1;
      end
      if (!found) begin
        total++; bad++;
        $display("FAIL coincide_setup: got no rvalid+gnt cycle want one");
      end
      pc_sel_i = 2'b01;
      target_i = 32'h0000_0200;
    end
    expect_first("coincide_pc", 32'h0000_0200);

    // Address wrap at the top of the address space
    step();
    pc_sel_i = 2'b01;
    target_i = 32'hFFFF_FFF8;
    expect_first("wrap_pc0", 32'hFFFF_FFF8);
    expect_first("wrap_pc1", 32'hFFFF_FFFC);
    expect_first("wrap_pc2", 32'h0000_0000);

    // Asynchronous reset in the middle of a drain
    redirect_with_pending(32'h0000_0300);
    step();
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("arst_inst", inst_o, 32'd0);
    check("arst_pc", pc_o, 32'd0);
    check("arst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("arst_req", {31'b0, imem_req_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    mem_q.delete();
    gnt_pct = 0;
    repeat (3) begin
      step();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = $urandom;
    end
    gnt_pct = 100;
    step();
    check("restart_req", {31'b0, imem_req_o}, 32'd1);
    check("restart_addr", imem_addr_o, RESET_PC);
    expect_first("restart_pc", RESET_PC);

    // Randomized traffic
    gnt_pct = 70; stall_pct = 20; redir_pct = 5; lat_min = 0; lat_max = 2;
    repeat (3000) step();
    gnt_pct = 100; stall_pct = 0; redir_pct = 0;
    repeat (30) step();
    total++;
    if (n_insts < 300) begin
      bad++;
      $display("FAIL throughput: got %0d insts want >= 300", n_insts);
    end
    total++;
    if (exp_q.size() > 4) begin
      bad++;
      $display("FAIL backlog: got %0d pending want <= 4", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
